// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial signed adder, LSB first, one bit per clock, with
//             start/done handshake and positive/negative overflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             OvP,
    output logic             OvN
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             sign_a;
    logic             sign_b;

    logic             bit_s;
    logic             carry_nx;
    logic [WIDTH-1:0] r_next;

    // Single full-adder cell shared across all bit positions.
    assign bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign r_next   = {bit_s, r_sh};

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            sum    <= '0;
            OvP    <= 1'b0;
            OvN    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        sign_a <= A[WIDTH-1];
                        sign_b <= B[WIDTH-1];
                        carry  <= 1'b0;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry <= carry_nx;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next[WIDTH-1:1];
                    cnt   <= cnt + CNT_W'(1);
                    // Final bit: the MSB just computed completes the result.
                    if (cnt == LAST_BIT) begin
                        sum   <= r_next;
                        OvP   <= ~sign_a & ~sign_b &  bit_s;
                        OvN   <=  sign_a &  sign_b & ~bit_s;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Scoreboard bench for serial_adder: directed vectors, handshake
//             timing, asynchronous reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       ovp;
    logic       ovn;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] s;
        logic       p;
        logic       n;
    } exp_t;

    exp_t exp_q[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .OvP   (ovp),
        .OvN   (ovn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 with sum=%0h, expected no completion", sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", {24'd0, sum}, {24'd0, e.s});
                    check("OvP", {31'd0, ovp}, {31'd0, e.p});
                    check("OvN", {31'd0, ovn}, {31'd0, e.n});
                end
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected within 8", n);
        end
    endtask

    task automatic do_add(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] es, input logic ep, input logic en);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back({es, ep, en});
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sum",  {24'd0, sum},  32'd0);
        check("reset_flags", {30'd0, ovp, ovn}, 32'd0);
        rst_n = 1'b1;

        // Directed vectors, expected values worked out by hand.
        do_add(8'd100, 8'd40,  8'h8C, 1'b1, 1'b0);   // 100+40   -> -116, OvP
        do_add(8'h9C,  8'hD8,  8'h74, 1'b0, 1'b1);   // -100-40  -> 116, OvN
        do_add(8'h80,  8'hFF,  8'h7F, 1'b0, 1'b1);   // -128-1   -> 127, OvN
        do_add(8'd100, 8'hD8,  8'h3C, 1'b0, 1'b0);   // 100-40   -> 60
        do_add(8'd40,  8'h9C,  8'hC4, 1'b0, 1'b0);   // 40-100   -> -60
        do_add(8'h7F,  8'h01,  8'h80, 1'b1, 1'b0);   // 127+1    -> -128, OvP
        do_add(8'hFF,  8'h01,  8'h00, 1'b0, 1'b0);   // -1+1     -> 0
        do_add(8'h80,  8'h80,  8'h00, 1'b0, 1'b1);   // -128-128 -> 0, OvN
        do_add(8'h7F,  8'h80,  8'hFF, 1'b0, 1'b0);   // 127-128  -> -1
        do_add(8'h00,  8'h00,  8'h00, 1'b0, 1'b0);
        do_add(8'h55,  8'h2A,  8'h7F, 1'b0, 1'b0);   // 85+42    -> 127

        // Handshake: start held high; sample k is the negedge after edge E0+k.
        @(negedge clk);
        a = 8'd100;
        b = 8'hD8;
        start = 1'b1;
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            check($sformatf("hs_busy_%0d", k), {31'd0, busy},
                  {31'd0, (k <= 7) || (k >= 10 && k <= 17)});
            check($sformatf("hs_done_%0d", k), {31'd0, done},
                  {31'd0, (k == 8) || (k == 18)});
            case (k)
                9: begin
                    a = 8'd40;
                    b = 8'h9C;
                    exp_q.push_back({8'hC4, 1'b0, 1'b0});
                end
                10: start = 1'b0;
                12: begin
                    a = 8'd5;
                    b = 8'd5;
                end
                14: start = 1'b1;
                15: begin
                    start = 1'b0;
                    check("hs_sum_hold", {24'd0, sum}, 32'h3C);
                end
                18: start = 1'b1;
                19: start = 1'b0;
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of bit 4.
        @(negedge clk);
        a = 8'd100;
        b = 8'd40;
        start = 1'b1;
        exp_q.push_back({8'h8C, 1'b1, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum",  {24'd0, sum},  32'd0);
        check("abort_flags", {30'd0, ovp, ovn}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_add(8'd1, 8'd1, 8'h02, 1'b0, 1'b0);

        // Additional operands cross-checked against a plain A+B model.
        for (int i = 0; i < 100; i++) begin
            logic [7:0] x, y, s;
            x = 8'($urandom);
            y = 8'($urandom);
            s = x + y;
            do_add(x, y, s, ~x[7] & ~y[7] & s[7], x[7] & y[7] & ~s[7]);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
